// File: rtl/svmod_pkg.sv
// Shared types and default constants for the ICE break sequencer.
package svmod_pkg;

    // Width of the shared sequencing / timeout counter
    localparam int TMR_W        = 10;

    // Default sequencing constants
    localparam int WAKE_CYC_DEF = 4;
    localparam int ACK_TMO_DEF  = 1023;
    localparam int PERI_DLY_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAKE  = 3'd1,
        REQ   = 3'd2,
        BREAK = 3'd3,
        REL   = 3'd4,
        OPBRK = 3'd5
    } state_t;

endpackage

// File: rtl/sv_ack_timer.sv
// Clear/enable counter that saturates at SAT, with a compare against a
// selectable terminal count. Drives wake length, peripheral delay and the
// ack timeouts of the break sequencer.
module sv_ack_timer
    import svmod_pkg::*;
#(
    parameter int               W   = TMR_W,
    parameter logic [W-1:0]     SAT = '1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Count up while enabled, hold at the saturation value, clear has priority
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (en && (cnt != SAT))
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/svmod_break_seq.sv
// ICE-side break sequencer: wake from standby, request SV mode, hold the
// break, release, with ack timeouts. MONSVMOD is the acknowledge.
// Optional break-entry counter enabled by defining SVMOD_BRKCNT_EN.
module svmod_break_seq
    import svmod_pkg::*;
#(
    parameter int WAKE_CYC = WAKE_CYC_DEF,
    parameter int ACK_TMO  = ACK_TMO_DEF,
    parameter int PERI_DLY = PERI_DLY_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRKREQ,
    input  logic        OPBRKREQ,
    input  logic        RUNREQ,
    input  logic        PERI0EN,
    input  logic        PERI1EN,
    input  logic        STBMD,
    input  logic        MONSVMOD,
`ifdef SVMOD_BRKCNT_EN
    input  logic        BRKCNTCLR,
    output logic [15:0] BRKCNT,
`endif
    output logic        SVMODI,
    output logic        SVMODIPERI1,
    output logic        SVMODIPERI2,
    output logic        SVMODOPBRK,
    output logic        STBRELESV,
    output logic        BRKSTAT,
    output logic        OPBSTAT,
    output logic        TMOERR
);

    localparam logic [TMR_W-1:0] WAKE_TC  = TMR_W'(WAKE_CYC - 1);
    localparam logic [TMR_W-1:0] ACK_TC   = TMR_W'(ACK_TMO - 1);
    localparam logic [TMR_W-1:0] ACK_SAT  = TMR_W'(ACK_TMO);
    localparam logic [TMR_W:0]   PERI_THR = (TMR_W+1)'(PERI_DLY);

    state_t             state, state_nxt;
    logic               tmo_hit;
    logic               opb_hold, opb_nxt;
    logic               peri_ok;
    logic               tmr_clr;
    logic [TMR_W-1:0]   tmr_cnt, tmr_tc_val;
    logic               tmr_tc;

    // WAKE measures its own length; every other state compares against the ack timeout
    assign tmr_tc_val = (state == WAKE) ? WAKE_TC : ACK_TC;
    // Counter restarts on every state change, including reset
    assign tmr_clr    = RESET || (state_nxt != state);

    sv_ack_timer #(
        .W   (TMR_W),
        .SAT (ACK_SAT)
    ) u_tmr (
        .clk    (CLK),
        .clr    (tmr_clr),
        .en     (1'b1),
        .tc_val (tmr_tc_val),
        .cnt    (tmr_cnt),
        .tc     (tmr_tc)
    );

    // Next-state decode; tmo_hit flags an expired ack wait
    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (BRKREQ)
                    state_nxt = STBMD ? WAKE : REQ;
                else if (OPBRKREQ)
                    state_nxt = OPBRK;
            end
            WAKE: begin
                if (tmr_tc)
                    state_nxt = REQ;
            end
            REQ: begin
                if (MONSVMOD)
                    state_nxt = BREAK;
                else if (tmr_tc) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            BREAK: begin
                if (RUNREQ)
                    state_nxt = REL;
            end
            REL: begin
                if (!MONSVMOD)
                    state_nxt = IDLE;
                else if (tmr_tc) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            OPBRK: begin
                // A full break request takes precedence over resume
                if (BRKREQ)
                    state_nxt = STBMD ? WAKE : REQ;
                else if (RUNREQ)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Track an open break escalated to a full break: its stop line is held until REL
    always_comb begin
        opb_nxt = opb_hold;
        if ((state == OPBRK) && ((state_nxt == WAKE) || (state_nxt == REQ)))
            opb_nxt = 1'b1;
        else if ((state_nxt == REL) || (state_nxt == IDLE))
            opb_nxt = 1'b0;
    end

    // Peripheral stops follow PERI_DLY cycles into BREAK (counter value of the next cycle)
    always_comb begin
        peri_ok = 1'b0;
        if (state_nxt == BREAK) begin
            if (state != BREAK)
                peri_ok = (PERI_DLY == 0);
            else
                peri_ok = (({1'b0, tmr_cnt} + (TMR_W+1)'(1)) >= PERI_THR);
        end
    end

    // State register and registered outputs, all decoded from the next state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            opb_hold    <= 1'b0;
            SVMODI      <= 1'b0;
            SVMODIPERI1 <= 1'b0;
            SVMODIPERI2 <= 1'b0;
            SVMODOPBRK  <= 1'b0;
            STBRELESV   <= 1'b0;
            BRKSTAT     <= 1'b0;
            OPBSTAT     <= 1'b0;
            TMOERR      <= 1'b0;
        end else begin
            state       <= state_nxt;
            opb_hold    <= opb_nxt;
            SVMODI      <= (state_nxt == REQ) || (state_nxt == BREAK);
            SVMODIPERI1 <= peri_ok && PERI1EN;
            SVMODIPERI2 <= peri_ok && PERI0EN;
            SVMODOPBRK  <= (state_nxt == OPBRK) ||
                           (opb_nxt && ((state_nxt == WAKE) || (state_nxt == REQ) ||
                                        (state_nxt == BREAK)));
            STBRELESV   <= (state_nxt == WAKE);
            BRKSTAT     <= (state_nxt == BREAK);
            OPBSTAT     <= (state_nxt == OPBRK);
            // A fresh timeout wins over a simultaneous resume
            if (tmo_hit)
                TMOERR <= 1'b1;
            else if (RUNREQ)
                TMOERR <= 1'b0;
        end
    end

`ifdef SVMOD_BRKCNT_EN
    logic brk_entry;
    assign brk_entry = (state_nxt == BREAK) && (state != BREAK);

    // Saturating count of BREAK entries; a clear coinciding with an entry leaves 1
    always_ff @(posedge CLK) begin
        if (RESET)
            BRKCNT <= 16'd0;
        else if (BRKCNTCLR)
            BRKCNT <= brk_entry ? 16'd1 : 16'd0;
        else if (brk_entry && (BRKCNT != 16'hFFFF))
            BRKCNT <= BRKCNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_svmod_break_seq.sv
// Self-checking bench for svmod_break_seq: directed scenarios plus a
// randomized run against a behavioural model of the sequencing rules.
module tb_svmod_break_seq;

    localparam int WAKE_CYC = 4;
    localparam int ACK_TMO  = 1023;
    localparam int PERI_DLY = 2;

    logic clk = 1'b0;
    logic rst, brkreq, opbrkreq, runreq, pe0, pe1, stbmd, mon;
    logic svmodi, peri1, peri2, svopbrk, stbrel, brkstat, opbstat, tmoerr;
    logic [7:0] outs;
`ifdef SVMOD_BRKCNT_EN
    logic        brkcntclr;
    logic [15:0] brkcnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign outs = {svmodi, peri1, peri2, svopbrk, stbrel, brkstat, opbstat, tmoerr};

    svmod_break_seq #(
        .WAKE_CYC (WAKE_CYC),
        .ACK_TMO  (ACK_TMO),
        .PERI_DLY (PERI_DLY)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .BRKREQ      (brkreq),
        .OPBRKREQ    (opbrkreq),
        .RUNREQ      (runreq),
        .PERI0EN     (pe0),
        .PERI1EN     (pe1),
        .STBMD       (stbmd),
        .MONSVMOD    (mon),
`ifdef SVMOD_BRKCNT_EN
        .BRKCNTCLR   (brkcntclr),
        .BRKCNT      (brkcnt),
`endif
        .SVMODI      (svmodi),
        .SVMODIPERI1 (peri1),
        .SVMODIPERI2 (peri2),
        .SVMODOPBRK  (svopbrk),
        .STBRELESV   (stbrel),
        .BRKSTAT     (brkstat),
        .OPBSTAT     (opbstat),
        .TMOERR      (tmoerr)
    );

    // One clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        brkreq = 0; opbrkreq = 0; runreq = 0;
        pe0 = 0; pe1 = 0; stbmd = 0; mon = 0;
`ifdef SVMOD_BRKCNT_EN
        brkcntclr = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick();
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL reset_outs got %b want 00000000", outs); end
        rst = 0; tick(); tick();
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL idle_outs got %b want 00000000", outs); end
    endtask

    // BRKREQ in cycle 10, ack in cycle 15: SVMODI at 11, BRKSTAT at 16, PERI2 at 18
    task automatic test_break_basic();
        do_reset();
        pe0 = 1; pe1 = 0;
        brkreq = 1; tick(); brkreq = 0;          // now cycle 11
        n_cmp++;
        if (svmodi !== 1'b1 || brkstat !== 1'b0) begin
            n_err++; $display("FAIL brk_latency svmodi=%b brkstat=%b want 1/0", svmodi, brkstat);
        end
        tick(); tick(); tick(); tick();          // cycle 15
        n_cmp++;
        if (svmodi !== 1'b1 || brkstat !== 1'b0) begin
            n_err++; $display("FAIL req_hold svmodi=%b brkstat=%b want 1/0", svmodi, brkstat);
        end
        mon = 1; tick();                         // cycle 16
        n_cmp++;
        if (brkstat !== 1'b1 || peri2 !== 1'b0) begin
            n_err++; $display("FAIL brk_entry brkstat=%b peri2=%b want 1/0", brkstat, peri2);
        end
        tick();                                  // cycle 17
        n_cmp++;
        if (peri2 !== 1'b0) begin n_err++; $display("FAIL peri_early peri2=%b want 0", peri2); end
        tick();                                  // cycle 18
        n_cmp++;
        if (peri2 !== 1'b1 || peri1 !== 1'b0 || svmodi !== 1'b1) begin
            n_err++; $display("FAIL peri_dly peri2=%b peri1=%b svmodi=%b want 1/0/1", peri2, peri1, svmodi);
        end
        pe1 = 1; tick();
        n_cmp++;
        if (peri1 !== 1'b1) begin n_err++; $display("FAIL peri_live peri1=%b want 1", peri1); end
    endtask

    // Continues from BREAK left by test_break_basic
    task automatic test_release();
        runreq = 1; tick(); runreq = 0;
        n_cmp++;
        if ({svmodi, peri1, peri2, brkstat} !== 4'b0000) begin
            n_err++; $display("FAIL rel_drop got %b want 0000", {svmodi, peri1, peri2, brkstat});
        end
        opbrkreq = 1; tick(); opbrkreq = 0;
        n_cmp++;
        if (svopbrk !== 1'b0 || opbstat !== 1'b0) begin
            n_err++; $display("FAIL rel_ignore_opb svopbrk=%b opbstat=%b want 0/0", svopbrk, opbstat);
        end
        tick();
        mon = 0; tick();
        opbrkreq = 1; tick(); opbrkreq = 0;
        n_cmp++;
        if (opbstat !== 1'b1 || svopbrk !== 1'b1) begin
            n_err++; $display("FAIL rel_to_idle opbstat=%b svopbrk=%b want 1/1", opbstat, svopbrk);
        end
        runreq = 1; tick(); runreq = 0;
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL opb_resume got %b want 00000000", outs); end
    endtask

    task automatic test_wake();
        int n;
        bit early;
        do_reset();
        stbmd = 1;
        brkreq = 1; tick(); brkreq = 0;
        n = 0; early = 0;
        while (stbrel === 1'b1 && n < 20) begin
            if (svmodi !== 1'b0) early = 1;
            n++; tick();
        end
        n_cmp++;
        if (n != WAKE_CYC || early) begin
            n_err++; $display("FAIL wake_len got %0d cycles (svmodi_early=%0d) want %0d", n, early, WAKE_CYC);
        end
        n_cmp++;
        if (svmodi !== 1'b1 || stbrel !== 1'b0) begin
            n_err++; $display("FAIL wake_to_req svmodi=%b stbrel=%b want 1/0", svmodi, stbrel);
        end
        // Resume during REQ is ignored
        runreq = 1; tick(); runreq = 0;
        n_cmp++;
        if (svmodi !== 1'b1) begin n_err++; $display("FAIL req_ignore_run svmodi=%b want 1", svmodi); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        brkreq = 1; tick(); brkreq = 0;
        n = 0;
        while (svmodi === 1'b1 && n < 2000) begin n++; tick(); end
        n_cmp++;
        if (n != ACK_TMO) begin n_err++; $display("FAIL tmo_len got %0d want %0d", n, ACK_TMO); end
        n_cmp++;
        if (tmoerr !== 1'b1 || svmodi !== 1'b0) begin
            n_err++; $display("FAIL tmo_flag tmoerr=%b svmodi=%b want 1/0", tmoerr, svmodi);
        end
        tick(); tick();
        n_cmp++;
        if (tmoerr !== 1'b1) begin n_err++; $display("FAIL tmo_sticky tmoerr=%b want 1", tmoerr); end
        runreq = 1; tick(); runreq = 0;
        n_cmp++;
        if (tmoerr !== 1'b0) begin n_err++; $display("FAIL tmo_clear tmoerr=%b want 0", tmoerr); end
    endtask

    task automatic test_opbrk();
        do_reset();
        opbrkreq = 1; tick(); opbrkreq = 0;
        n_cmp++;
        if (svopbrk !== 1'b1 || svmodi !== 1'b0 || opbstat !== 1'b1) begin
            n_err++; $display("FAIL opb_entry svopbrk=%b svmodi=%b opbstat=%b want 1/0/1", svopbrk, svmodi, opbstat);
        end
        brkreq = 1; tick(); brkreq = 0;
        n_cmp++;
        if (svmodi !== 1'b1 || svopbrk !== 1'b1 || opbstat !== 1'b0) begin
            n_err++; $display("FAIL opb_escalate svmodi=%b svopbrk=%b opbstat=%b want 1/1/0", svmodi, svopbrk, opbstat);
        end
        mon = 1; tick();
        n_cmp++;
        if (brkstat !== 1'b1 || svopbrk !== 1'b1) begin
            n_err++; $display("FAIL opb_break brkstat=%b svopbrk=%b want 1/1", brkstat, svopbrk);
        end
        runreq = 1; tick(); runreq = 0;
        n_cmp++;
        if (svmodi !== 1'b0 || svopbrk !== 1'b0) begin
            n_err++; $display("FAIL opb_release svmodi=%b svopbrk=%b want 0/0", svmodi, svopbrk);
        end
        mon = 0; tick();
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        brkreq = 1; opbrkreq = 1; tick(); brkreq = 0; opbrkreq = 0;
        n_cmp++;
        if (svmodi !== 1'b1 || svopbrk !== 1'b0 || opbstat !== 1'b0) begin
            n_err++; $display("FAIL both_req svmodi=%b svopbrk=%b opbstat=%b want 1/0/0", svmodi, svopbrk, opbstat);
        end
        pe0 = 1; pe1 = 1; mon = 1;
        tick(); tick(); tick(); tick();
        n_cmp++;
        if ({svmodi, peri1, peri2, brkstat} !== 4'b1111) begin
            n_err++; $display("FAIL full_break got %b want 1111", {svmodi, peri1, peri2, brkstat});
        end
        rst = 1; tick(); rst = 0;
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL mid_reset got %b want 00000000", outs); end
        tick();
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL post_reset got %b want 00000000", outs); end
        idle_inputs();
    endtask

`ifdef SVMOD_BRKCNT_EN
    task automatic test_brkcnt();
        do_reset();
        n_cmp++;
        if (brkcnt !== 16'd0) begin n_err++; $display("FAIL cnt_reset got %0d want 0", brkcnt); end
        for (int k = 0; k < 2; k++) begin
            brkreq = 1; tick(); brkreq = 0;
            mon = 1; tick();
            runreq = 1; tick(); runreq = 0;
            mon = 0; tick();
        end
        n_cmp++;
        if (brkcnt !== 16'd2) begin n_err++; $display("FAIL cnt_two got %0d want 2", brkcnt); end
        brkreq = 1; tick(); brkreq = 0;
        mon = 1; brkcntclr = 1; tick(); brkcntclr = 0;
        n_cmp++;
        if (brkcnt !== 16'd1) begin n_err++; $display("FAIL cnt_clr_entry got %0d want 1", brkcnt); end
        brkcntclr = 1; tick(); brkcntclr = 0;
        n_cmp++;
        if (brkcnt !== 16'd0) begin n_err++; $display("FAIL cnt_clr got %0d want 0", brkcnt); end
        idle_inputs(); tick();
    endtask
`endif

    // Randomized traffic against a rule-level model of the sequencer
    localparam int P_IDLE = 0, P_WAKE = 1, P_REQ = 2, P_BREAK = 3, P_REL = 4, P_OPBRK = 5;

    task automatic test_random();
        int  ph, el, nph, el_n, shown;
        bit  tmo, opb, tset;
        logic [7:0] expv;
        do_reset();
        ph = P_IDLE; el = 0; tmo = 0; opb = 0; shown = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            brkreq   = ($urandom_range(0, 99) < 4);
            opbrkreq = ($urandom_range(0, 99) < 4);
            runreq   = ($urandom_range(0, 99) < 6);
            rst      = ($urandom_range(0, 999) < 4);
            if ($urandom_range(0, 99) < 10) pe0 = ~pe0;
            if ($urandom_range(0, 99) < 10) pe1 = ~pe1;
            if ($urandom_range(0, 99) < 5)  stbmd = ~stbmd;
            if ($urandom_range(0, 99) < 25) mon = ~mon;

            if (rst) begin
                ph = P_IDLE; el = 0; tmo = 0; opb = 0; expv = 8'h00;
            end else begin
                nph = ph; tset = 0;
                if (ph == P_IDLE) begin
                    if (brkreq) nph = stbmd ? P_WAKE : P_REQ;
                    else if (opbrkreq) nph = P_OPBRK;
                end else if (ph == P_WAKE) begin
                    if (el == WAKE_CYC - 1) nph = P_REQ;
                end else if (ph == P_REQ) begin
                    if (mon) nph = P_BREAK;
                    else if (el == ACK_TMO - 1) begin nph = P_IDLE; tset = 1; end
                end else if (ph == P_BREAK) begin
                    if (runreq) nph = P_REL;
                end else if (ph == P_REL) begin
                    if (!mon) nph = P_IDLE;
                    else if (el == ACK_TMO - 1) begin nph = P_IDLE; tset = 1; end
                end else begin
                    if (brkreq) begin nph = stbmd ? P_WAKE : P_REQ; opb = 1; end
                    else if (runreq) nph = P_IDLE;
                end
                el_n = (nph == ph) ? el + 1 : 0;
                if (nph == P_REL || nph == P_IDLE) opb = 0;
                if (tset) tmo = 1;
                else if (runreq) tmo = 0;
                expv = {nph == P_REQ || nph == P_BREAK,
                        nph == P_BREAK && el_n >= PERI_DLY && pe1,
                        nph == P_BREAK && el_n >= PERI_DLY && pe0,
                        nph == P_OPBRK || (opb && (nph == P_WAKE || nph == P_REQ || nph == P_BREAK)),
                        nph == P_WAKE,
                        nph == P_BREAK,
                        nph == P_OPBRK,
                        tmo};
                ph = nph; el = el_n;
            end
            tick();
            n_cmp++;
            if (outs !== expv) begin
                n_err++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc %0d outs got %b want %b", cyc, outs, expv);
                end
            end
        end
        idle_inputs(); rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_break_basic();
        test_release();
        test_wake();
        test_timeout();
        test_opbrk();
        test_same_cycle_and_reset();
`ifdef SVMOD_BRKCNT_EN
        test_brkcnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
